// File: rtl/window_loader_if.sv
// Byte-stream and window-BRAM port-A bundle for the window loader.
// The pixel source and the control side drive the master modport. The loader
// implements the slave modport.
interface window_loader_if #(
    parameter int NUM_ROWS = 16,
    parameter int ADDR_W   = 10
);
    logic                start;     // pulse: load one window into the inactive bank
    logic [7:0]          pciIn;     // pixel byte
    logic                pciValid;  // pciIn holds a valid byte
    logic                pciReady;  // loader accepts a byte this cycle
    logic [NUM_ROWS-1:0] winWrite;  // one-hot row strobe to the BRAM port A
    logic [ADDR_W-1:0]   winAddr;   // port A address, shared by all rows
    logic [7:0]          winData;   // port A write data, shared by all rows
    logic                busy;      // window load in progress
    logic                done;      // one-cycle pulse: window complete
    logic                readBank;  // bank the correlator reads (last completed)

    modport master (
        output start, pciIn, pciValid,
        input  pciReady, winWrite, winAddr, winData, busy, done, readBank
    );

    modport slave (
        input  start, pciIn, pciValid,
        output pciReady, winWrite, winAddr, winData, busy, done, readBank
    );
endinterface

// File: rtl/window_loader.sv
// Search-window loader: streams raster-order pixel bytes into NUM_ROWS
// row BRAMs through port A. The BRAMs are double-buffered by bank. The correlator
// reads bank readBank while the next window fills the other bank.
// The interface instance must use the same NUM_ROWS and ADDR_W as this module.
module window_loader #(
    parameter int NUM_ROWS   = 16,
    parameter int ROW_PIXELS = 80,
    parameter int ADDR_W     = 10
) (
    input  logic           clk,
    input  logic           rst,
    window_loader_if.slave bus
);

    // Counter widths. Each width is kept at least one bit wide so that
    // degenerate parameter choices still elaborate.
    localparam int COL_W = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ROW_PIXELS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(ROW_PIXELS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic                load_bank;
    logic                read_bank;
    logic                xfer;
    logic                last_col;
    logic                last_pix;
    logic [ADDR_W-1:0]   bank_base;
    logic [NUM_ROWS-1:0] win_write;
    logic [ADDR_W-1:0]   win_addr;
    logic [7:0]          win_data;

    // A beat is accepted only in LOAD. pciReady is a pure decode of state.
    assign xfer      = (state == S_LOAD) && bus.pciValid;
    assign last_col  = (col == COL_LAST);
    assign last_pix  = last_col && (row == ROW_LAST);
    assign bank_base = load_bank ? BANK1_BASE : '0;

    // Next-state decode for IDLE -> LOAD -> DONE -> IDLE.
    always_comb begin
        // NOTE: defaulting every always_comb output before the case keeps
        // uncovered paths from inferring a latch.
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_LOAD;
            S_LOAD:  if (xfer && last_pix) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register. A reset in any state drops the partial window.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update together from the pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Raster position: col advances per beat and wraps into the next row.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (state == S_IDLE && bus.start) begin
            col <= '0;
            row <= '0;
        end else if (xfer) begin
            if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Bank swap at the end of DONE. The finished bank becomes readable,
    // and the next window goes to the other bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_bank <= 1'b0;
            read_bank <= 1'b0;
        end else if (state == S_DONE) begin
            read_bank <= load_bank;
            load_bank <= ~load_bank;
        end
    end

    // Registered BRAM port A: one strobe in the cycle after each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_write <= '0;
            win_addr  <= '0;
            win_data  <= '0;
        end else begin
            win_write <= xfer ? (NUM_ROWS'(1) << row) : '0;
            if (xfer) begin
                win_addr <= bank_base + ADDR_W'(col);
                win_data <= bus.pciIn;
            end
        end
    end

    assign bus.pciReady = (state == S_LOAD);
    assign bus.busy     = (state == S_LOAD);
    assign bus.done     = (state == S_DONE);
    assign bus.readBank = read_bank;
    assign bus.winWrite = win_write;
    assign bus.winAddr  = win_addr;
    assign bus.winData  = win_data;

    // Port A never sees more than one row strobe in a cycle.
    a_onehot_strobe: assert property (@(posedge clk) disable iff (rst)
        $onehot0(win_write));

    // Every strobe traces back to an accepted beat in the previous cycle.
    a_strobe_follows_xfer: assert property (@(posedge clk) disable iff (rst)
        (win_write != '0) |-> $past(xfer));

endmodule

// File: tb/tb_window_loader.sv
// Directed bench for window_loader. Each scenario task drives a window and
// compares the logged port-A strobes with an independent raster model.
module tb_window_loader;

    localparam int NUM_ROWS   = 16;
    localparam int ROW_PIXELS = 80;
    localparam int ADDR_W     = 10;
    localparam int TOTAL      = NUM_ROWS * ROW_PIXELS;
    localparam int BUDGET     = 8000;

    typedef struct packed {
        logic [NUM_ROWS-1:0] we;
        logic [ADDR_W-1:0]   addr;
        logic [7:0]          data;
        logic                done;
    } strobe_t;

    logic clk;
    logic rst;

    window_loader_if #(.NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W)) bus ();

    window_loader #(
        .NUM_ROWS  (NUM_ROWS),
        .ROW_PIXELS(ROW_PIXELS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    strobe_t log_q[$];
    int      done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every port-A strobe and every done pulse.
    always @(negedge clk) begin
        if (bus.winWrite != '0)
            log_q.push_back({bus.winWrite, bus.winAddr, bus.winData, bus.done});
        if (bus.done === 1'b1)
            done_cnt++;
    end

    // Model of the k-th strobe of a window that is loaded into the given bank.
    function automatic strobe_t exp_strobe(input int k, input int bank);
        strobe_t s;
        int r = k / ROW_PIXELS;
        int c = k % ROW_PIXELS;
        s.we    = '0;
        s.we[r] = 1'b1;
        s.addr  = ADDR_W'(bank * ROW_PIXELS + c);
        s.data  = 8'(k % 256);
        s.done  = (k == TOTAL - 1);
        return s;
    endfunction

    task automatic clear_log();
        log_q.delete();
        done_cnt = 0;
    endtask

    // Pulse start, then stream bytes (value = index mod 256) until TOTAL or
    // stop_at beats have been accepted. This task returns on the negedge after the
    // final counted transfer. For a full window, that negedge is the DONE cycle.
    task automatic drive_window(input bit gaps, input int start_at, input int stop_at,
                                output int xfers, output int ready_low);
        int idx    = 0;
        int cycles = 0;
        bit pend   = 1'b0;
        bit pulsed = 1'b0;
        ready_low = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.pciValid = 1'b0;
        @(negedge clk);
        forever begin
            if (pend) idx++;
            pend      = 1'b0;
            bus.start = 1'b0;
            if (idx == TOTAL || idx == stop_at || cycles > BUDGET) break;
            if (bus.pciReady !== 1'b1) ready_low++;
            bus.pciValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.pciIn    = idx[7:0];
            if (idx == start_at && !pulsed) begin
                bus.start = 1'b1;
                pulsed    = 1'b1;
            end
            pend = bus.pciValid && (bus.pciReady === 1'b1);
            cycles++;
            @(negedge clk);
        end
        bus.pciValid = 1'b0;
        xfers = idx;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.pciValid = 1'b1;
        bus.pciIn    = 8'hA5;
        repeat (2) @(negedge clk);
        clear_log();
        tests_run++;
        if (bus.winWrite !== '0) begin tests_failed++; $display("FAIL reset_winWrite got %h want 0", bus.winWrite); end
        tests_run++;
        if (bus.winAddr !== '0) begin tests_failed++; $display("FAIL reset_winAddr got %h want 0", bus.winAddr); end
        tests_run++;
        if (bus.winData !== '0) begin tests_failed++; $display("FAIL reset_winData got %h want 0", bus.winData); end
        tests_run++;
        if (bus.pciReady !== 1'b0) begin tests_failed++; $display("FAIL reset_pciReady got %b want 0", bus.pciReady); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done); end
        tests_run++;
        if (bus.readBank !== 1'b0) begin tests_failed++; $display("FAIL reset_readBank got %b want 0", bus.readBank); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (log_q.size() != 0) begin tests_failed++; $display("FAIL idle_no_strobe got %0d strobes want 0", log_q.size()); end
        tests_run++;
        if (bus.pciReady !== 1'b0) begin tests_failed++; $display("FAIL idle_pciReady got %b want 0", bus.pciReady); end
        bus.pciValid = 1'b0;
    endtask

    task automatic test_full_load();
        int xfers, ready_low;
        clear_log();
        drive_window(1'b0, -1, -1, xfers, ready_low);
        tests_run++;
        if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL full_done_pulse got %b want 1", bus.done); end
        tests_run++;
        if (bus.readBank !== 1'b0) begin tests_failed++; $display("FAIL full_readBank_in_done got %b want 0", bus.readBank); end
        @(negedge clk);
        tests_run++;
        if (xfers != TOTAL) begin tests_failed++; $display("FAIL full_xfers got %0d want %0d", xfers, TOTAL); end
        tests_run++;
        if (log_q.size() != TOTAL) begin tests_failed++; $display("FAIL full_strobe_count got %0d want %0d", log_q.size(), TOTAL); end
        for (int k = 0; k < TOTAL && k < log_q.size(); k++) begin
            tests_run++;
            if (log_q[k] !== exp_strobe(k, 0)) begin
                tests_failed++;
                $display("FAIL full_strobe[%0d] got %h want %h", k, log_q[k], exp_strobe(k, 0));
            end
        end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
        tests_run++;
        if (bus.readBank !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL full_after_done got readBank=%b busy=%b want 0 0", bus.readBank, bus.busy);
        end
    endtask

    task automatic test_gapped_load();
        int xfers, ready_low;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        drive_window(1'b1, -1, -1, xfers, ready_low);
        @(negedge clk);
        tests_run++;
        if (xfers != TOTAL) begin tests_failed++; $display("FAIL gap_xfers got %0d want %0d", xfers, TOTAL); end
        tests_run++;
        if (ready_low != 0) begin tests_failed++; $display("FAIL gap_pciReady_low got %0d cycles want 0", ready_low); end
        tests_run++;
        if (log_q.size() != TOTAL) begin tests_failed++; $display("FAIL gap_strobe_count got %0d want %0d", log_q.size(), TOTAL); end
        for (int k = 0; k < TOTAL && k < log_q.size(); k++) begin
            tests_run++;
            if (log_q[k] !== exp_strobe(k, 0)) begin
                tests_failed++;
                $display("FAIL gap_strobe[%0d] got %h want %h", k, log_q[k], exp_strobe(k, 0));
            end
        end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("FAIL gap_done_count got %0d want 1", done_cnt); end
    endtask

    // Back-to-back windows: bank 1 and then bank 0 again. readBank follows each done.
    task automatic test_bank_alternation();
        int xfers, ready_low;
        for (int w = 0; w < 2; w++) begin
            int bank = (w == 0) ? 1 : 0;
            clear_log();
            drive_window(1'b0, -1, -1, xfers, ready_low);
            tests_run++;
            if (bus.readBank !== 1'(1 - bank)) begin
                tests_failed++; $display("FAIL alt%0d_readBank_in_done got %b want %0d", w, bus.readBank, 1 - bank);
            end
            @(negedge clk);
            tests_run++;
            if (bus.readBank !== 1'(bank)) begin
                tests_failed++; $display("FAIL alt%0d_readBank_after got %b want %0d", w, bus.readBank, bank);
            end
            tests_run++;
            if (log_q.size() != TOTAL) begin tests_failed++; $display("FAIL alt%0d_strobe_count got %0d want %0d", w, log_q.size(), TOTAL); end
            for (int k = 0; k < TOTAL && k < log_q.size(); k++) begin
                tests_run++;
                if (log_q[k] !== exp_strobe(k, bank)) begin
                    tests_failed++;
                    $display("FAIL alt%0d_strobe[%0d] got %h want %h", w, k, log_q[k], exp_strobe(k, bank));
                end
            end
        end
    endtask

    // A start pulse during LOAD is ignored, and a reset during LOAD aborts the window.
    task automatic test_mid_load_start_and_reset();
        int xfers, ready_low;
        clear_log();
        drive_window(1'b0, 300, 500, xfers, ready_low);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (bus.winWrite !== '0 || bus.winAddr !== '0 || bus.winData !== '0) begin
            tests_failed++;
            $display("FAIL abort_port_zero got we=%h addr=%h data=%h want 0 0 0", bus.winWrite, bus.winAddr, bus.winData);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.pciReady !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_ctrl_zero got busy=%b ready=%b done=%b want 0 0 0", bus.busy, bus.pciReady, bus.done);
        end
        tests_run++;
        if (log_q.size() != 500) begin tests_failed++; $display("FAIL abort_strobe_count got %0d want 500", log_q.size()); end
        for (int k = 0; k < 500 && k < log_q.size(); k++) begin
            tests_run++;
            if (log_q[k] !== exp_strobe(k, 1)) begin
                tests_failed++;
                $display("FAIL abort_strobe[%0d] got %h want %h", k, log_q[k], exp_strobe(k, 1));
            end
        end
        tests_run++;
        if (done_cnt != 0) begin tests_failed++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end

        clear_log();
        drive_window(1'b0, -1, -1, xfers, ready_low);
        @(negedge clk);
        tests_run++;
        if (log_q.size() != TOTAL) begin tests_failed++; $display("FAIL fresh_strobe_count got %0d want %0d", log_q.size(), TOTAL); end
        for (int k = 0; k < TOTAL && k < log_q.size(); k++) begin
            tests_run++;
            if (log_q[k] !== exp_strobe(k, 0)) begin
                tests_failed++;
                $display("FAIL fresh_strobe[%0d] got %h want %h", k, log_q[k], exp_strobe(k, 0));
            end
        end
        tests_run++;
        if (bus.readBank !== 1'b0) begin tests_failed++; $display("FAIL fresh_readBank got %b want 0", bus.readBank); end
    endtask

    // A start pulse in the DONE cycle is ignored. A start pulse one cycle later begins LOAD.
    task automatic test_start_in_done();
        int xfers, ready_low;
        clear_log();
        drive_window(1'b0, -1, -1, xfers, ready_low);
        tests_run++;
        if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL sid_done got %b want 1", bus.done); end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL sid_busy_after_done_start got %b want 0", bus.busy); end
        tests_run++;
        if (bus.readBank !== 1'b1) begin tests_failed++; $display("FAIL sid_readBank got %b want 1", bus.readBank); end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1 || bus.pciReady !== 1'b1) begin
            tests_failed++; $display("FAIL sid_load_begins got busy=%b ready=%b want 1 1", bus.busy, bus.pciReady);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (log_q.size() != TOTAL) begin tests_failed++; $display("FAIL sid_no_extra_strobe got %0d want %0d", log_q.size(), TOTAL); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gapped_load();
        test_bank_alternation();
        test_mid_load_start_and_reset();
        test_start_in_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
